// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte per frame, LSB first, start/data/[parity]/stop(s).
// Latency: tx goes low on the accepting edge; frame lasts (9+parity+STOP_BITS)*BAUD_CNT clocks.
// Backpressure: ready is high only in IDLE; a new byte is accepted no sooner than one clock after the previous frame.
module uart_tx #(
    parameter int TX_BAUD   = 9600,
    parameter int CLK_FQC   = 50_000_000,
    parameter int BAUD_CNT  = CLK_FQC / TX_BAUD,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    // Baud counter only needs to reach BAUD_CNT-1.
    localparam int                CNT_W     = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BAUD_CNT - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    // Reject parameter sets the frame logic cannot honour.
    if (BAUD_CNT < 2) begin : g_bad_baud
        $error("uart_tx: BAUD_CNT must be at least 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;   // data bit index in DATA, stop bit index in STOP
    logic [7:0]       shift;
    logic             par_bit;
    logic             bit_end;

    // Last clock of the current bit period.
    assign bit_end = (baud_cnt == BAUD_LAST);

    // Frame sequencer: all outputs registered, tx only moves on bit boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid) begin
                        // Parity is taken from the byte being latched so later data changes cannot leak in.
                        shift    <= data;
                        par_bit  <= (PARITY == 1) ? ~(^data) : (^data);
                        state    <= S_START;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= 1'b0;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                default: begin
                    if (!bit_end) begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end else begin
                        baud_cnt <= '0;
                        case (state)
                            S_START: begin
                                state   <= S_DATA;
                                tx      <= shift[0];
                                shift   <= {1'b0, shift[7:1]};
                                bit_cnt <= '0;
                            end
                            S_DATA: begin
                                if (bit_cnt == 3'd7) begin
                                    bit_cnt <= '0;
                                    if (PARITY != 0) begin
                                        state <= S_PARITY;
                                        tx    <= par_bit;
                                    end else begin
                                        state <= S_STOP;
                                        tx    <= 1'b1;
                                    end
                                end else begin
                                    tx      <= shift[0];
                                    shift   <= {1'b0, shift[7:1]};
                                    bit_cnt <= bit_cnt + 3'd1;
                                end
                            end
                            S_PARITY: begin
                                state   <= S_STOP;
                                tx      <= 1'b1;
                                bit_cnt <= '0;
                            end
                            S_STOP: begin
                                if (bit_cnt == STOP_LAST) begin
                                    state <= S_IDLE;
                                    tx    <= 1'b1;
                                    ready <= 1'b1;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end else begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                end
                            end
                            default: begin
                                state <= S_IDLE;
                                tx    <= 1'b1;
                                ready <= 1'b1;
                                busy  <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter that serialises 8-bit bytes onto a single line, LSB first, in the frame format already used by the UART receiver: idle high, start bit low, 8 data bits, optional parity, 1 or 2 stop bits high. It accepts bytes over a valid/ready handshake and sits between the system logic and the board TX pin. It pairs with uart_rx, so loopback benches can drive uart_rx directly from this block.

Parameters:
TX_BAUD, 9600, nominal baud rate (documentation/default derivation only)
CLK_FQC, 50_000_000, clock frequency in Hz
BAUD_CNT, CLK_FQC/TX_BAUD, clocks per bit; benches override it (e.g. 50) for short sims; legal range ≥2
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
data  input  8  byte to send, sampled on handshake
valid  input  1  data is valid
ready  output  1  high when able to accept a byte (IDLE)
tx  output  1  serial line, registered
busy  output  1  high while a frame is in progress (not IDLE)
done  output  1  one-cycle pulse when the final stop bit completes

Behaviour:
- Reset (rst high on an edge): state is IDLE, tx=1, ready=1, busy=0, done=0, bit counter=0, baud counter=0. Reset aborts any frame in progress; tx returns high on the next edge. valid is ignored while rst is high.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, ready=1. On an edge with valid=1 the block latches data into the shift register, computes parity from the latched byte, and moves to START. On that same edge it sets tx=0, ready=0 and busy=1.
- Every non-IDLE state holds tx for exactly BAUD_CNT clocks. The baud counter runs 0..BAUD_CNT-1 and wraps to 0 on each bit boundary.
- START: tx=0, then goes to DATA.
- DATA: tx=shift[0], shifting right once per bit. After 8 bits it goes to PARITY if PARITY≠0, otherwise to STOP.
- PARITY: for even, tx is the XOR of the 8 bits. For odd, tx is the inverse of that XOR.
- STOP: tx=1 for STOP_BITS×BAUD_CNT clocks. On the final clock it returns to IDLE, pulses done=1 for one cycle, and sets ready=1 and busy=0.
- Frame length is (1+8+(PARITY≠0)+STOP_BITS)×BAUD_CNT clocks, from the acceptance edge to the edge where ready rises.
- Back-to-back: if valid is held high, the next byte is accepted on the first IDLE cycle. This gives exactly 1 clock of extra idle-high between frames, which is the minimum inter-frame gap.
- Changes on data or valid while busy are ignored. The latched byte is unaffected.
- The baud counter is sized to hold BAUD_CNT-1. No glitches: tx changes only on bit boundaries and at reset.

Test Plan:
- Reset, then check idle: rst high for 5 clocks, then low → tx=1, ready=1, busy=0, done=0; tx stays 1 for 100 clocks with valid=0.
- Single byte: BAUD_CNT=50, PARITY=0, STOP_BITS=1, send 0xAF. Expected:
  - tx sequence 0,1,1,1,1,0,1,0,1,1, each level held 50 clocks;
  - done pulses once, 500 clocks after acceptance;
  - ready low for those 500 clocks.
- Back-to-back: valid held high with 0xAF then 0x56.
  - Second frame bits: 0,0,1,1,0,1,0,1,0,1.
  - Exactly 1 idle-high clock between frames.
  - uart_rx in loopback (same BAUD_CNT) reports 0xAF then 0x56 with ready pulses.
- Parity and stop bits, with STOP_BITS=2:
  - PARITY=2 with 0xAF → parity bit 0.
  - PARITY=1 with 0x56 → parity bit 1.
  - Frame is 12×50=600 clocks, and the stop level lasts 100 clocks.
- Mid-frame reset: rst asserted during data bit 3 of 0xAF → tx=1, ready=1 on the next edge. A new 0x56 sent afterwards is a complete, correct frame.
- Data change while busy: switch data from 0xAF to 0x00 one clock after acceptance → 0xAF is still transmitted; valid pulses during busy are not accepted (no extra frame).
